dffram_arbiter2: RTL and testbench

- Two-requester arbiter and sequencer in front of one single-port RAM1024 DFFRAM macro (EN0/A0/Di0/Do0/WE0).
- Lets two masters share one 256x32 macro with zero-wait access, e.g. an AHB-lite wrapper and a DMA/streaming engine.
- Provides per-cycle round-robin arbitration, optional locked bursts with a bounded lock length, and per-port read-return routing.

---
 rtl/dffram_arbiter2_if.sv | 49 ++++
 rtl/dffram_arbiter2.sv | 173 +++++++++++++++++
 tb/tb_dffram_arbiter2.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dffram_arbiter2_if.sv
// ---------------------------------------------------------------------------
// dffram_arbiter2_if
// Purpose : bundles the two requester ports and the DFFRAM macro pins that
//           surround dffram_arbiter2.
// Members : req0/1, lock0/1, we0/1[3:0], addr0/1[AW-3:0], wdata0/1[31:0]
//           gnt0/1, rvalid0/1, rdata0/1[31:0]
//           ram_en, ram_we[3:0], ram_addr[AW-3:0], ram_wdata[31:0], ram_do[31:0]
// Modports: slave  - the arbiter itself
//           master - the requesters plus the macro model that returns ram_do
// ---------------------------------------------------------------------------
interface dffram_arbiter2_if #(
    parameter int AW = 10
);
    logic            req0;
    logic            req1;
    logic            lock0;
    logic            lock1;
    logic [3:0]      we0;
    logic [3:0]      we1;
    logic [AW-3:0]   addr0;
    logic [AW-3:0]   addr1;
    logic [31:0]     wdata0;
    logic [31:0]     wdata1;
    logic            gnt0;
    logic            gnt1;
    logic            rvalid0;
    logic            rvalid1;
    logic [31:0]     rdata0;
    logic [31:0]     rdata1;
    logic            ram_en;
    logic [3:0]      ram_we;
    logic [AW-3:0]   ram_addr;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_do;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1,
               wdata0, wdata1, ram_do,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1,
               wdata0, wdata1, ram_do,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/dffram_arbiter2.sv
// ---------------------------------------------------------------------------
// dffram_arbiter2
// Purpose : two-requester arbiter/sequencer in front of one single-port
//           RAM1024 DFFRAM macro (256 x 32). Per-cycle round-robin or fixed
//           priority arbitration, locked bursts bounded to MAX_LOCK cycles,
//           and per-port routing of the one-cycle-latency read data.
// Ports   : HCLK     - clock
//           HRESETn  - asynchronous active-low reset
//           bus      - dffram_arbiter2_if.slave (requester ports + macro pins)
// Params  : AW       - byte address width (word address is AW-2 bits)
//           MAX_LOCK - longest locked ownership in granted cycles (2..255)
//           RR       - 1 round-robin, 0 fixed priority with port 0 highest
// ---------------------------------------------------------------------------
module dffram_arbiter2 #(
    parameter int AW       = 10,
    parameter int MAX_LOCK = 8,
    parameter int RR       = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    dffram_arbiter2_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [7:0]    lock_cnt_q, lock_cnt_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    logic          sel1;
    logic          gnt0_c, gnt1_c;
    logic [3:0]    we_mux;
    logic [AW-3:0] addr_mux;
    logic [31:0]   wdata_mux;

    // Arbitration and ownership
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        sel1       = 1'b0;
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    sel1 = (RR != 0) ? ~last_q : 1'b0;
                end else begin
                    sel1 = bus.req1;
                end
                gnt0_c = bus.req0 && !sel1;
                gnt1_c = bus.req1 && sel1;
                if (gnt0_c && bus.lock0) begin
                    state_d    = OWN0;
                    lock_cnt_d = 8'd1;
                end else if (gnt1_c && bus.lock1) begin
                    state_d    = OWN1;
                    lock_cnt_d = 8'd1;
                end
            end

            // Owner keeps the macro even on cycles it does not request;
            // those cycles still count toward the bound.
            OWN0: begin
                gnt0_c     = bus.req0;
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (!bus.lock0 || lock_cnt_q == LOCK_LAST) begin
                    state_d    = IDLE;
                    lock_cnt_d = 8'd0;
                    last_d     = 1'b0;
                end
            end

            OWN1: begin
                gnt1_c     = bus.req1;
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (!bus.lock1 || lock_cnt_q == LOCK_LAST) begin
                    state_d    = IDLE;
                    lock_cnt_d = 8'd0;
                    last_d     = 1'b1;
                end
            end

            default: begin
                state_d    = IDLE;
                lock_cnt_d = 8'd0;
            end
        endcase

        if (gnt0_c) begin
            last_d = 1'b0;
        end else if (gnt1_c) begin
            last_d = 1'b1;
        end

        rvalid0_d = gnt0_c && (bus.we0 == 4'b0000);
        rvalid1_d = gnt1_c && (bus.we1 == 4'b0000);
    end

    // Macro drive: granted port's attributes, all zero when idle
    always_comb begin
        we_mux    = 4'b0000;
        addr_mux  = '0;
        wdata_mux = 32'h0;
        if (gnt0_c) begin
            we_mux    = bus.we0;
            addr_mux  = bus.addr0;
            wdata_mux = bus.wdata0;
        end else if (gnt1_c) begin
            we_mux    = bus.we1;
            addr_mux  = bus.addr1;
            wdata_mux = bus.wdata1;
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.ram_en    = gnt0_c | gnt1_c;
    assign bus.ram_we    = we_mux;
    assign bus.ram_addr  = addr_mux;
    assign bus.ram_wdata = wdata_mux;

    // Registered state; the macro registers Do on the same edge as rvalid
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= 8'd0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    // Read return routing
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rvalid0_q ? bus.ram_do : 32'h0;
    assign bus.rdata1  = rvalid1_q ? bus.ram_do : 32'h0;

    // A waiting requester must not change its attributes while it still requests
    property p_hold0;
        @(posedge HCLK) disable iff (!HRESETn)
        (bus.req0 && !bus.gnt0) |=>
            (!bus.req0 || ($stable(bus.we0) && $stable(bus.addr0) &&
                           $stable(bus.wdata0) && $stable(bus.lock0)));
    endproperty

    property p_hold1;
        @(posedge HCLK) disable iff (!HRESETn)
        (bus.req1 && !bus.gnt1) |=>
            (!bus.req1 || ($stable(bus.we1) && $stable(bus.addr1) &&
                           $stable(bus.wdata1) && $stable(bus.lock1)));
    endproperty

    a_hold0: assert property (p_hold0);
    a_hold1: assert property (p_hold1);

endmodule

// File: tb/tb_dffram_arbiter2.sv
module tb_dffram_arbiter2;
    localparam int AW = 10;

    logic HCLK = 1'b0;
    logic HRESETn;
    int   checks = 0;
    int   errors = 0;

    always #5 HCLK = ~HCLK;

    dffram_arbiter2_if #(.AW(AW)) bus_rr ();
    dffram_arbiter2_if #(.AW(AW)) bus_fp ();

    dffram_arbiter2 #(.AW(AW), .MAX_LOCK(8), .RR(1)) u_rr (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus_rr)
    );

    dffram_arbiter2 #(.AW(AW), .MAX_LOCK(8), .RR(0)) u_fp (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus_fp)
    );

    // Behavioural RAM1024 macro: Do registered on a read edge, unchanged on writes
    logic [31:0] mem [0:255];
    logic [31:0] do_q;

    always @(posedge HCLK) begin
        if (bus_rr.ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_rr.ram_we[b]) mem[bus_rr.ram_addr][8*b +: 8] <= bus_rr.ram_wdata[8*b +: 8];
            end
            if (bus_rr.ram_we == 4'b0000) do_q <= mem[bus_rr.ram_addr];
        end
    end

    assign bus_rr.ram_do = do_q;
    assign bus_fp.ram_do = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic p0(input logic r, input logic l, input logic [3:0] w,
                      input logic [7:0] a, input logic [31:0] d);
        bus_rr.req0 = r; bus_rr.lock0 = l; bus_rr.we0 = w; bus_rr.addr0 = a; bus_rr.wdata0 = d;
    endtask

    task automatic p1(input logic r, input logic l, input logic [3:0] w,
                      input logic [7:0] a, input logic [31:0] d);
        bus_rr.req1 = r; bus_rr.lock1 = l; bus_rr.we1 = w; bus_rr.addr1 = a; bus_rr.wdata1 = d;
    endtask

    task automatic fp(input logic r0, input logic r1);
        bus_fp.req0 = r0; bus_fp.lock0 = 1'b0; bus_fp.we0 = 4'h0; bus_fp.addr0 = 8'd1; bus_fp.wdata0 = 32'h0;
        bus_fp.req1 = r1; bus_fp.lock1 = 1'b0; bus_fp.we1 = 4'h0; bus_fp.addr1 = 8'd2; bus_fp.wdata1 = 32'h0;
    endtask

    initial begin
        HRESETn = 1'b0;
        p0(0, 0, 4'h0, 8'd0, 32'h0);
        p1(0, 0, 4'h0, 8'd0, 32'h0);
        fp(0, 0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        chk("rst_gnt0",    bus_rr.gnt0, 0);
        chk("rst_gnt1",    bus_rr.gnt1, 0);
        chk("rst_rvalid0", bus_rr.rvalid0, 0);
        chk("rst_rvalid1", bus_rr.rvalid1, 0);
        chk("rst_ram_en",  bus_rr.ram_en, 0);
        chk("rst_rdata0",  bus_rr.rdata0, 0);

        // Port 0 write then read of addr 5
        @(negedge HCLK); p0(1, 0, 4'hF, 8'd5, 32'hDEADBEEF); #1;
        chk("t1_wr_gnt0",  bus_rr.gnt0, 1);
        chk("t1_wr_we",    bus_rr.ram_we, 4'hF);
        chk("t1_wr_addr",  bus_rr.ram_addr, 8'd5);
        chk("t1_wr_data",  bus_rr.ram_wdata, 32'hDEADBEEF);
        @(negedge HCLK); p0(1, 0, 4'h0, 8'd5, 32'h0); #1;
        chk("t1_rd_gnt0",  bus_rr.gnt0, 1);
        chk("t1_wr_norv",  bus_rr.rvalid0, 0);
        chk("t1_rd_we",    bus_rr.ram_we, 4'h0);
        @(negedge HCLK); p0(0, 0, 4'h0, 8'd0, 32'h0); #1;
        chk("t1_rvalid0",  bus_rr.rvalid0, 1);
        chk("t1_rdata0",   bus_rr.rdata0, 32'hDEADBEEF);
        chk("t1_rvalid1",  bus_rr.rvalid1, 0);
        chk("t1_idle_en",  bus_rr.ram_en, 0);
        chk("t1_idle_adr", bus_rr.ram_addr, 8'd0);
        @(negedge HCLK); #1;
        chk("t1_rv0_drop", bus_rr.rvalid0, 0);
        chk("t1_rd0_zero", bus_rr.rdata0, 32'h0);

        // Byte write into preloaded word, read back through port 1
        @(negedge HCLK); p0(1, 0, 4'hF, 8'd3, 32'h11223344); #1;
        chk("t4_pre_gnt0", bus_rr.gnt0, 1);
        @(negedge HCLK); p0(1, 0, 4'b0100, 8'd3, 32'h00AA0000); #1;
        chk("t4_bw_gnt0",  bus_rr.gnt0, 1);
        chk("t4_bw_we",    bus_rr.ram_we, 4'b0100);
        @(negedge HCLK); p0(0, 0, 4'h0, 8'd0, 32'h0); p1(1, 0, 4'h0, 8'd3, 32'h0); #1;
        chk("t4_rd_gnt1",  bus_rr.gnt1, 1);
        chk("t4_rd_gnt0",  bus_rr.gnt0, 0);
        chk("t4_rd_addr",  bus_rr.ram_addr, 8'd3);
        @(negedge HCLK); p1(0, 0, 4'h0, 8'd0, 32'h0); #1;
        chk("t4_rvalid1",  bus_rr.rvalid1, 1);
        chk("t4_rdata1",   bus_rr.rdata1, 32'h11AA3344);
        chk("t4_rvalid0",  bus_rr.rvalid0, 0);
        chk("t4_rdata0",   bus_rr.rdata0, 32'h0);

        // Both ports read every cycle, round-robin alternation
        @(negedge HCLK); p0(1, 0, 4'h0, 8'd5, 32'h0); p1(1, 0, 4'h0, 8'd3, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_gnt0",    bus_rr.gnt0, (i % 2 == 0));
            chk("t2_gnt1",    bus_rr.gnt1, (i % 2 == 1));
            chk("t2_rvalid0", bus_rr.rvalid0, (i % 2 == 1));
            chk("t2_rvalid1", bus_rr.rvalid1, (i > 0 && i % 2 == 0));
            chk("t2_rdata0",  bus_rr.rdata0, (i % 2 == 1) ? 32'hDEADBEEF : 32'h0);
            chk("t2_rdata1",  bus_rr.rdata1, (i > 0 && i % 2 == 0) ? 32'h11AA3344 : 32'h0);
            @(negedge HCLK);
        end
        p0(0, 0, 4'h0, 8'd0, 32'h0); p1(0, 0, 4'h0, 8'd0, 32'h0); #1;
        chk("t2_tail_rv1", bus_rr.rvalid1, 1);
        chk("t2_tail_rd1", bus_rr.rdata1, 32'h11AA3344);
        chk("t2_tail_rv0", bus_rr.rvalid0, 0);

        // Write right after a read keeps the read's data
        @(negedge HCLK); p0(1, 0, 4'h0, 8'd5, 32'h0); #1;
        chk("mx_rd_gnt0",  bus_rr.gnt0, 1);
        @(negedge HCLK); p0(1, 0, 4'hF, 8'd5, 32'h12345678); #1;
        chk("mx_wr_gnt0",  bus_rr.gnt0, 1);
        chk("mx_rvalid0",  bus_rr.rvalid0, 1);
        chk("mx_rdata0",   bus_rr.rdata0, 32'hDEADBEEF);
        @(negedge HCLK); p0(1, 0, 4'h0, 8'd5, 32'h0); #1;
        chk("mx_wr_norv",  bus_rr.rvalid0, 0);
        @(negedge HCLK); p0(0, 0, 4'h0, 8'd0, 32'h0); #1;
        chk("mx_new_data", bus_rr.rdata0, 32'h12345678);

        // Port 1 locked burst against continuous port 0 requests
        @(negedge HCLK); p0(1, 0, 4'h0, 8'd5, 32'h0); p1(1, 1, 4'h0, 8'd3, 32'h0);
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk("t3_gnt1",    bus_rr.gnt1, (i != 9));
            chk("t3_gnt0",    bus_rr.gnt0, (i == 9));
            chk("t3_rvalid1", bus_rr.rvalid1, (i >= 2 && i <= 9));
            chk("t3_rdata1",  bus_rr.rdata1, (i >= 2 && i <= 9) ? 32'h11AA3344 : 32'h0);
            chk("t3_rvalid0", bus_rr.rvalid0, (i == 10));
            @(negedge HCLK);
        end
        p1(1, 0, 4'h0, 8'd3, 32'h0); #1;
        chk("t3_rel_gnt1", bus_rr.gnt1, 1);
        chk("t3_rel_gnt0", bus_rr.gnt0, 0);
        @(negedge HCLK); #1;
        chk("t3_aft_gnt0", bus_rr.gnt0, 1);
        chk("t3_aft_gnt1", bus_rr.gnt1, 0);
        @(negedge HCLK); p0(0, 0, 4'h0, 8'd0, 32'h0); p1(0, 0, 4'h0, 8'd0, 32'h0);

        // Fixed priority instance: port 0 always wins
        fp(1, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t5_fp_gnt0", bus_fp.gnt0, 1);
            chk("t5_fp_gnt1", bus_fp.gnt1, 0);
            @(negedge HCLK);
        end
        fp(0, 0);

        // Reset during the cycle after a granted (locked) read
        @(negedge HCLK); p0(1, 1, 4'h0, 8'd5, 32'h0); #1;
        chk("t6_gnt0",     bus_rr.gnt0, 1);
        @(negedge HCLK); p0(0, 1, 4'h0, 8'd5, 32'h0); #1;
        chk("t6_rvalid0",  bus_rr.rvalid0, 1);
        chk("t6_rdata0",   bus_rr.rdata0, 32'h12345678);
        #2; HRESETn = 1'b0; #1;
        chk("t6_rst_rv0",  bus_rr.rvalid0, 0);
        chk("t6_rst_rd0",  bus_rr.rdata0, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        p0(1, 0, 4'h0, 8'd5, 32'h0); p1(1, 0, 4'h0, 8'd3, 32'h0); #1;
        chk("t6_first_g0", bus_rr.gnt0, 1);
        chk("t6_first_g1", bus_rr.gnt1, 0);
        @(negedge HCLK); #1;
        chk("t6_next_g1",  bus_rr.gnt1, 1);
        chk("t6_next_g0",  bus_rr.gnt0, 0);
        chk("t6_next_rv0", bus_rr.rvalid0, 1);
        chk("t6_next_rd0", bus_rr.rdata0, 32'h12345678);
        @(negedge HCLK); p0(0, 0, 4'h0, 8'd0, 32'h0); p1(0, 0, 4'h0, 8'd0, 32'h0); #1;
        chk("t6_end_rv1",  bus_rr.rvalid1, 1);
        chk("t6_end_rd1",  bus_rr.rdata1, 32'h11AA3344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
